// File: rtl/alu_multicycle_20.sv
// alu_multicycle_20: one-cycle add/sub, WIDTH-cycle shift-add multiply and restoring divide.
// Define ALU_REM_EN to add the remainder output.
module alu_multicycle_20 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             div0
`ifdef ALU_REM_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, d0_q, d0_d;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0] rem_q, rem_d;
`endif

    logic             is_mul, div_ge, add_v, sub_v;
    logic [WIDTH:0]   add_s, sub_s, mul_s, div_sh;
    logic [WIDTH-1:0] div_df, it_hi, it_lo;

    assign is_mul = op_q == OP_MUL;
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign sub_s  = {1'b0, a} - {1'b0, b};
    assign add_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);

    // Multiply: {hi,lo} holds the partial product with the multiplier shifting out of lo.
    assign mul_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // Divide: hi is the partial remainder, quotient bits shift into lo as dividend bits leave.
    assign div_sh = {hi_q, lo_q[WIDTH-1]};
    assign div_ge = div_sh >= {1'b0, m_q};
    assign div_df = div_sh[WIDTH-1:0] - m_q;
    assign it_hi  = is_mul ? mul_s[WIDTH:1] : (div_ge ? div_df : div_sh[WIDTH-1:0]);
    assign it_lo  = is_mul ? {mul_s[0], lo_q[WIDTH-1:1]} : {lo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        d0_d    = d0_q;
`ifdef ALU_REM_EN
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = ALUControl;
                    m_d   = (ALUControl == OP_MUL) ? a : b;
                    lo_d  = (ALUControl == OP_MUL) ? b : a;
                    hi_d  = '0;
                    cnt_d = '0;
                    if (ALUControl == OP_MUL || (ALUControl == OP_DIV && b != '0)) begin
                        state_d = RUN;
                    end else begin
                        // Single-cycle ops, reserved codes and divide-by-zero finish straight away.
                        state_d = DONE;
                        res_d   = (ALUControl == OP_ADD) ? add_s[WIDTH-1:0] :
                                  (ALUControl == OP_SUB) ? sub_s[WIDTH-1:0] :
                                  (ALUControl == OP_DIV) ? '1 : '0;
                        c_d     = (ALUControl == OP_ADD) ? add_s[WIDTH] :
                                  (ALUControl == OP_SUB) ? sub_s[WIDTH] : 1'b0;
                        v_d     = (ALUControl == OP_ADD) ? add_v :
                                  (ALUControl == OP_SUB) ? sub_v : 1'b0;
                        d0_d    = ALUControl == OP_DIV;
                        z_d     = !ALUControl[2] && res_d == '0;
                        n_d     = res_d[WIDTH-1];
`ifdef ALU_REM_EN
                        rem_d   = (ALUControl == OP_DIV) ? a : '0;
`endif
                    end
                end
            end
            RUN: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    res_d   = it_lo;
                    z_d     = it_lo == '0;
                    n_d     = it_lo[WIDTH-1];
                    c_d     = 1'b0;
                    v_d     = is_mul && it_hi != '0;
                    d0_d    = 1'b0;
`ifdef ALU_REM_EN
                    rem_d   = is_mul ? '0 : it_hi;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            d0_q    <= 1'b0;
`ifdef ALU_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            d0_q    <= d0_d;
`ifdef ALU_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign result = res_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;
    assign div0   = d0_q;
`ifdef ALU_REM_EN
    assign remainder = rem_q;
`endif
endmodule
